// File: rtl/iob_eth_rx_mii.sv
// MII receive engine: strips preamble/SFD, packs nibbles into bytes for the RX buffer,
// checks the FCS and holds the finished frame until the DMA/CSR side acknowledges it.
module iob_eth_rx_mii #(
  parameter int BUF_ADDR_W = 11,
  parameter int MAX_BYTES  = 1536,
  parameter int MIN_BYTES  = 5
) (
  input  logic                  rx_clk_i,
  input  logic                  arst_n_i,
  input  logic                  rx_dv_i,
  input  logic [3:0]            rx_data_i,
  output logic                  wr_o,
  output logic [BUF_ADDR_W-1:0] addr_o,
  output logic [7:0]            data_o,
  output logic                  received_o,
  input  logic                  rcv_ack_i,
  output logic [BUF_ADDR_W-1:0] nbytes_o,
  output logic                  crc_err_o,
  output logic                  dropped_o
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, DATA_LO, DATA_HI, DONE, DROP
  } state_t;

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;
  localparam logic [BUF_ADDR_W-1:0] MAX_CNT = BUF_ADDR_W'(MAX_BYTES);
  localparam logic [BUF_ADDR_W-1:0] MIN_CNT = BUF_ADDR_W'(MIN_BYTES);
  localparam logic [BUF_ADDR_W-1:0] ONE     = BUF_ADDR_W'(1);

  // Reflected CRC-32, one byte per call, LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  state_t                state_q, state_d;
  logic [BUF_ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]           crc_q, crc_d;
  logic [3:0]            lo_q, lo_d;
  logic                  wr_q, wr_d;
  logic [BUF_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  rcv_q, rcv_d;
  logic                  err_q, err_d;
  logic                  drop_q, drop_d;
  logic                  dv_q;
  logic                  frame_end;
  logic [7:0]            byte_w;

  assign byte_w = {rx_data_i, lo_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    lo_d      = lo_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    rcv_d     = rcv_q;
    err_d     = err_q;
    drop_d    = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      IDLE: begin
        // A frame already in flight (e.g. after reset) is skipped silently.
        if (rx_dv_i)
          state_d = (rx_data_i == 4'h5) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!rx_dv_i) begin
          state_d = IDLE;
        end else if (rx_data_i == 4'hD) begin
          state_d = DATA_LO;
          cnt_d   = '0;
          crc_d   = CRC_INIT;
        end else if (rx_data_i != 4'h5) begin
          state_d = DROP;
          drop_d  = 1'b1;
        end
      end
      DATA_LO: begin
        if (rx_dv_i) begin
          lo_d    = rx_data_i;
          state_d = DATA_HI;
        end else begin
          frame_end = 1'b1;
        end
      end
      DATA_HI: begin
        if (rx_dv_i) begin
          if (cnt_q < MAX_CNT) begin
            wr_d    = 1'b1;
            addr_d  = cnt_q;
            data_d  = byte_w;
            cnt_d   = cnt_q + ONE;
            crc_d   = crc_byte(crc_q, byte_w);
            state_d = DATA_LO;
          end else begin
            state_d = DROP;
            drop_d  = 1'b1;
          end
        end else begin
          // Odd nibble count: the dangling low nibble is simply not stored.
          frame_end = 1'b1;
        end
      end
      DONE: begin
        // Every dv rising edge while a frame is held is one discarded frame.
        if (rx_dv_i && !dv_q)
          drop_d = 1'b1;
        if (rcv_ack_i) begin
          rcv_d   = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          crc_d   = CRC_INIT;
          state_d = rx_dv_i ? DROP : IDLE;
        end
      end
      DROP: begin
        if (!rx_dv_i)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (frame_end) begin
      if (cnt_q < MIN_CNT) begin
        state_d = IDLE;
        drop_d  = 1'b1;
      end else begin
        state_d = DONE;
        rcv_d   = 1'b1;
        err_d   = (crc_q != CRC_RES);
      end
    end
  end

  always_ff @(posedge rx_clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      crc_q   <= CRC_INIT;
      lo_q    <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rcv_q   <= 1'b0;
      err_q   <= 1'b0;
      drop_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      lo_q    <= lo_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rcv_q   <= rcv_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      dv_q    <= rx_dv_i;
    end
  end

  assign wr_o       = wr_q;
  assign addr_o     = addr_q;
  assign data_o     = data_q;
  assign received_o = rcv_q;
  assign nbytes_o   = cnt_q;
  assign crc_err_o  = err_q;
  assign dropped_o  = drop_q;

endmodule

// File: tb/tb_iob_eth_rx_mii.sv
// Directed bench for iob_eth_rx_mii: expected buffer writes go to a scoreboard queue,
// frame status and drop pulses are checked after each frame.
module tb_iob_eth_rx_mii;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          arst_n, rx_dv, rcv_ack;
  logic [3:0]    rx_data;
  logic          wr_o, received_o, crc_err_o, dropped_o;
  logic [AW-1:0] addr_o, nbytes_o;
  logic [7:0]    data_o;

  int total = 0;
  int bad   = 0;
  int drop_cnt = 0;
  int d0;
  logic [7:0]    frm[$];
  logic [18:0]   sb[$];

  iob_eth_rx_mii #(.BUF_ADDR_W(AW), .MAX_BYTES(1536), .MIN_BYTES(5)) dut (
    .rx_clk_i(clk), .arst_n_i(arst_n), .rx_dv_i(rx_dv), .rx_data_i(rx_data),
    .wr_o(wr_o), .addr_o(addr_o), .data_o(data_o), .received_o(received_o),
    .rcv_ack_i(rcv_ack), .nbytes_o(nbytes_o), .crc_err_o(crc_err_o), .dropped_o(dropped_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Write monitor / scoreboard consumer, sampled away from the active edge.
  always @(negedge clk) begin
    logic [18:0] e;
    if (dropped_o) drop_cnt++;
    if (wr_o) begin
      chk("wr_expected", 32'(wr_o), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wr_addr", 32'(addr_o), 32'(e[18:8]));
        chk("wr_data", 32'(data_o), 32'(e[7:0]));
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Payload of n bytes plus FCS; optionally flip one payload byte after the FCS is computed.
  task automatic build_frame(input int n, input int seed, input int flip);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    frm.delete();
    for (int i = 0; i < n; i++) begin
      frm.push_back(8'(i * 37 + seed));
      c = crc_upd(c, frm[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) frm.push_back(8'(c >> (8 * i)));
    if (flip >= 0) frm[flip] = frm[flip] ^ 8'h01;
  endtask

  task automatic nib(input logic dv, input logic [3:0] d);
    rx_dv = dv;
    rx_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    rcv_ack = 1'b1;
    nib(1'b0, 4'h0);
    rcv_ack = 1'b0;
    chk("ack_received", 32'(received_o), 0);
    chk("ack_crc_err", 32'(crc_err_o), 0);
  endtask

  // Sends frm with a 15x5+D preamble; nexp leading bytes are expected in the buffer.
  task automatic send(input int nexp, input bit tail, input int rst_nib);
    logic [3:0] nq[$];
    for (int i = 0; i < 15; i++) nq.push_back(4'h5);
    nq.push_back(4'hD);
    foreach (frm[i]) begin
      nq.push_back(frm[i][3:0]);
      nq.push_back(frm[i][7:4]);
    end
    if (tail) nq.push_back(4'h3);
    for (int i = 0; i < nexp; i++) sb.push_back({11'(i), frm[i]});
    foreach (nq[j]) begin
      if (j == rst_nib) begin
        arst_n = 1'b0;
        #1;
        chk("rst_wr", 32'(wr_o), 0);
        chk("rst_addr", 32'(addr_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_received", 32'(received_o), 0);
        chk("rst_dropped", 32'(dropped_o), 0);
      end
      if (j == rst_nib + 2) arst_n = 1'b1;
      nib(1'b1, nq[j]);
    end
    nib(1'b0, 4'h0);
  endtask

  initial begin
    arst_n = 1'b0; rx_dv = 1'b0; rx_data = 4'h0; rcv_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr", 32'(wr_o), 0);
    chk("reset_addr", 32'(addr_o), 0);
    chk("reset_data", 32'(data_o), 0);
    chk("reset_received", 32'(received_o), 0);
    chk("reset_nbytes", 32'(nbytes_o), 0);
    chk("reset_crc_err", 32'(crc_err_o), 0);
    chk("reset_dropped", 32'(dropped_o), 0);
    arst_n = 1'b1;
    nib(1'b0, 4'h0);
    rcv_ack = 1'b1;
    nib(1'b0, 4'h0);
    rcv_ack = 1'b0;
    chk("idle_ack_ignored", 32'(received_o), 0);

    // 1: good 64-byte frame
    build_frame(60, 8'h11, -1);
    send(64, 1'b0, -1);
    chk("t1_received", 32'(received_o), 1);
    chk("t1_nbytes", 32'(nbytes_o), 64);
    chk("t1_crc_err", 32'(crc_err_o), 0);
    chk("t1_sb_drained", 32'(sb.size()), 0);
    repeat (3) nib(1'b0, 4'h0);
    chk("t1_received_held", 32'(received_o), 1);
    ack();

    // 2: payload byte 10 corrupted
    build_frame(60, 8'h11, 10);
    send(64, 1'b0, -1);
    chk("t2_received", 32'(received_o), 1);
    chk("t2_nbytes", 32'(nbytes_o), 64);
    chk("t2_crc_err", 32'(crc_err_o), 1);
    ack();

    // 3: 1537-byte frame overflows
    d0 = drop_cnt;
    build_frame(1533, 8'h5A, -1);
    send(1536, 1'b0, -1);
    repeat (2) nib(1'b0, 4'h0);
    chk("t3_drops", 32'(drop_cnt - d0), 1);
    chk("t3_received", 32'(received_o), 0);
    chk("t3_sb_drained", 32'(sb.size()), 0);

    // 4: frame arriving while one is held
    build_frame(60, 8'h01, -1);
    send(64, 1'b0, -1);
    chk("t4_received", 32'(received_o), 1);
    d0 = drop_cnt;
    build_frame(40, 8'h02, -1);
    send(0, 1'b0, -1);
    nib(1'b0, 4'h0);
    chk("t4_drops", 32'(drop_cnt - d0), 1);
    chk("t4_nbytes_kept", 32'(nbytes_o), 64);
    chk("t4_received_kept", 32'(received_o), 1);
    chk("t4_crc_err_kept", 32'(crc_err_o), 0);
    ack();
    build_frame(10, 8'h03, -1);
    send(14, 1'b0, -1);
    chk("t4c_received", 32'(received_o), 1);
    chk("t4c_nbytes", 32'(nbytes_o), 14);
    chk("t4c_crc_err", 32'(crc_err_o), 0);
    chk("t4c_sb_drained", 32'(sb.size()), 0);
    ack();

    // 5a: bad SFD
    d0 = drop_cnt;
    repeat (8) nib(1'b1, 4'h5);
    nib(1'b1, 4'hA);
    repeat (4) nib(1'b1, 4'h1);
    repeat (2) nib(1'b0, 4'h0);
    chk("t5a_drops", 32'(drop_cnt - d0), 1);
    chk("t5a_received", 32'(received_o), 0);
    // 5b: runt 3-byte frame
    d0 = drop_cnt;
    frm.delete();
    frm.push_back(8'h01); frm.push_back(8'h02); frm.push_back(8'h03);
    send(3, 1'b0, -1);
    nib(1'b0, 4'h0);
    chk("t5b_drops", 32'(drop_cnt - d0), 1);
    chk("t5b_received", 32'(received_o), 0);
    chk("t5b_sb_drained", 32'(sb.size()), 0);
    // 5c: odd nibble tail on a good frame
    build_frame(16, 8'h04, -1);
    send(20, 1'b1, -1);
    chk("t5c_received", 32'(received_o), 1);
    chk("t5c_nbytes", 32'(nbytes_o), 20);
    chk("t5c_crc_err", 32'(crc_err_o), 0);
    ack();

    // 6: reset for 2 cycles at byte 20; payload avoids nibble 5 so the tail is skipped
    d0 = drop_cnt;
    frm.delete();
    repeat (64) frm.push_back(8'hA7);
    send(20, 1'b0, 16 + 2 * 20 + 1);
    repeat (2) nib(1'b0, 4'h0);
    chk("t6_no_drop", 32'(drop_cnt - d0), 0);
    chk("t6_received", 32'(received_o), 0);
    chk("t6_sb_drained", 32'(sb.size()), 0);
    build_frame(26, 8'h05, -1);
    send(30, 1'b0, -1);
    chk("t6b_received", 32'(received_o), 1);
    chk("t6b_nbytes", 32'(nbytes_o), 30);
    chk("t6b_crc_err", 32'(crc_err_o), 0);
    chk("t6b_sb_drained", 32'(sb.size()), 0);
    ack();

    repeat (2) nib(1'b0, 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
